systolic_array_ctrl: RTL and testbench
======================================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4: idle-input cycles after each window feed before the result is captured.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: begin one job; sampled only in IDLE.
REQ-005 Port in_valid, input, 1: in_data is valid.
REQ-006 Port in_data, input, 8: weight or pixel byte.
REQ-007 Port in_ready, output, 1: controller accepts in_data this cycle.
REQ-008 Port busy, output, 1: high in every state except IDLE.
REQ-009 Port done, output, 1: one-cycle pulse at job end.
REQ-010 Port b_out, output, 72: weights, B11 in [7:0] through B33 in [71:64], row-major.
REQ-011 Port en_reg_B, output, 9: weight-register load enables, bit k for weight k.
REQ-012 Port en_reg_A and en_reg_Acc, output, 1 each: array pipeline enables.
REQ-013 Port row1_in, row2_in and row3_in, output, 8 each: array row operands.
REQ-014 Port sel_en_demux_result and sel_en_demux_c_reg, output, 2 each: result-register select.
REQ-015 Port input_demux_c_reg, output, 1: result-register write strobe.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_W, LOAD_X, PRELOAD, FEED, DRAIN, WRITE, FIN.
REQ-017 IDLE -> LOAD_W on start=1; start is ignored in every other state.
REQ-018 in_ready=1 only in LOAD_W and LOAD_X; a beat transfers when in_valid and in_ready are both 1.
REQ-019 LOAD_W stores 9 beats, in row-major order, into weight registers W0..W8, then moves to LOAD_X.
REQ-020 LOAD_X stores 16 beats, row-major, into pixel buffer X[r][c] (r,c = 0..3), then moves to PRELOAD.
REQ-021 in_valid=0 stalls the beat counter; no timeout.
REQ-022 PRELOAD lasts 1 cycle with en_reg_B=9'h1FF, then moves to FEED with window index p=0; en_reg_B=0 in every other state.
REQ-023 b_out continuously reflects W0..W8.
REQ-024 Window p (0..3) uses r0=p[1] and c0=p[0].
REQ-025 FEED lasts 3 cycles j=0..2 and drives row1_in=X[r0][c0+j], row2_in=X[r0+1][c0+j], row3_in=X[r0+2][c0+j].
REQ-026 row*_in SHALL be 8'h00 in every state except FEED.
REQ-027 DRAIN lasts DRAIN_CYCLES cycles.
REQ-028 en_reg_A=en_reg_Acc=1 in FEED and DRAIN only.
REQ-029 WRITE lasts 1 cycle with input_demux_c_reg=1 and both selects equal to p.
REQ-030 After WRITE: if p<3, increment p and go to FEED; if p=3, go to FIN.
REQ-031 Both selects hold p in FEED, DRAIN and WRITE, and are 0 otherwise.
REQ-032 FIN lasts 1 cycle with done=1, then moves to IDLE; the buffers retain their contents.
REQ-033 Counters SHALL saturate at their terminal values; no wrap into the next phase without the state transition.
REQ-034 Job latency from the last pixel beat to done SHALL be 1 + 4*(3+DRAIN_CYCLES+1) + 1 cycles, which is 34 for the default.

Reset
REQ-035 While rst=1: state=IDLE; p, beat and phase counters=0; W and X=0.
REQ-036 While rst=1, every output SHALL be 0, including in_ready, busy, done, en_reg_B and the row inputs.
REQ-037 Reset asserted mid-job SHALL abort the job with no done pulse; the next start begins a fresh LOAD_W.

Verification
REQ-038 Reset mid-LOAD_X after 5 pixels, then a new job -> no done pulse for the aborted job; the new job needs the full 9+16 beats.
REQ-039 Weights 1..9 and pixels 0..15 streamed with in_valid=1 -> PRELOAD shows b_out[7:0]=1 and b_out[71:64]=9.
REQ-040 Same stimulus, window p=3 FEED -> row1/row2/row3 read 5,9,13, then 6,10,14, then 7,11,15.
REQ-041 in_valid toggled 1010... during load -> exactly 25 beats accepted, with no duplicates or skips.
REQ-042 Same stimulus -> done occurs 34 cycles after the last beat, with 4 WRITE strobes whose selects are 0,1,2,3.
REQ-043 start pulsed during FEED -> ignored; exactly one done pulse is produced.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Sequencing controller for a 3x3 systolic array: loads 9 weights and a 4x4 pixel
// tile, then feeds the four 3x3 windows through the array and strobes each result out.
module systolic_array_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [71:0] b_out,
  output logic [8:0]  en_reg_B,
  output logic        en_reg_A,
  output logic        en_reg_Acc,
  output logic [7:0]  row1_in,
  output logic [7:0]  row2_in,
  output logic [7:0]  row3_in,
  output logic [1:0]  sel_en_demux_result,
  output logic [1:0]  sel_en_demux_c_reg,
  output logic        input_demux_c_reg
);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_X, PRELOAD, FEED, DRAIN, WRITE, FIN
  } state_t;

  // Phase counter covers both the 3 FEED columns and the DRAIN count.
  localparam int PW = (DRAIN_CYCLES > 3) ? $clog2(DRAIN_CYCLES) : 2;
  localparam logic [PW-1:0] FEED_LAST  = PW'(2);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES - 1);

  state_t        state_q;
  logic [3:0]    beat_q;
  logic [PW-1:0] phase_q;
  logic [1:0]    p_q;
  logic [1:0]    sel_q;
  logic          en_pipe_q;
  logic [7:0]    w_q [9];
  logic [7:0]    x_q [16];

  // Window p starts at row p[1], column p[0]; {r,c} is the row-major index r*4+c.
  function automatic logic [7:0] pix(input logic [1:0] p, input logic [1:0] j,
                                     input logic [1:0] roff);
    logic [1:0] r;
    logic [1:0] c;
    r = {1'b0, p[1]} + roff;
    c = {1'b0, p[0]} + j;
    return x_q[{r, c}];
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      beat_q            <= '0;
      phase_q           <= '0;
      p_q               <= '0;
      sel_q             <= '0;
      en_pipe_q         <= 1'b0;
      in_ready          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      en_reg_B          <= '0;
      row1_in           <= '0;
      row2_in           <= '0;
      row3_in           <= '0;
      input_demux_c_reg <= 1'b0;
      // NOTE: the buffers are small and must read as zero after reset, so they are
      // real flops with reset rather than an inferred RAM.
      for (int k = 0; k < 9; k++)  w_q[k] <= '0;
      for (int k = 0; k < 16; k++) x_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= LOAD_W;
            beat_q   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD_W: begin
          if (in_valid) begin
            w_q[beat_q] <= in_data;
            if (beat_q == 4'd8) begin
              beat_q  <= '0;
              state_q <= LOAD_X;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        LOAD_X: begin
          if (in_valid) begin
            x_q[beat_q] <= in_data;
            if (beat_q == 4'd15) begin
              state_q  <= PRELOAD;
              in_ready <= 1'b0;
              en_reg_B <= 9'h1FF;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        PRELOAD: begin
          state_q   <= FEED;
          en_reg_B  <= '0;
          p_q       <= '0;
          phase_q   <= '0;
          sel_q     <= '0;
          en_pipe_q <= 1'b1;
          row1_in   <= pix(2'd0, 2'd0, 2'd0);
          row2_in   <= pix(2'd0, 2'd0, 2'd1);
          row3_in   <= pix(2'd0, 2'd0, 2'd2);
        end
        FEED: begin
          if (phase_q == FEED_LAST) begin
            state_q <= DRAIN;
            phase_q <= '0;
            row1_in <= '0;
            row2_in <= '0;
            row3_in <= '0;
          end else begin
            phase_q <= phase_q + PW'(1);
            row1_in <= pix(p_q, phase_q[1:0] + 2'd1, 2'd0);
            row2_in <= pix(p_q, phase_q[1:0] + 2'd1, 2'd1);
            row3_in <= pix(p_q, phase_q[1:0] + 2'd1, 2'd2);
          end
        end
        DRAIN: begin
          if (phase_q == DRAIN_LAST) begin
            state_q           <= WRITE;
            phase_q           <= '0;
            en_pipe_q         <= 1'b0;
            input_demux_c_reg <= 1'b1;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        WRITE: begin
          input_demux_c_reg <= 1'b0;
          if (p_q == 2'd3) begin
            state_q <= FIN;
            sel_q   <= '0;
            done    <= 1'b1;
          end else begin
            state_q   <= FEED;
            p_q       <= p_q + 2'd1;
            sel_q     <= p_q + 2'd1;
            en_pipe_q <= 1'b1;
            row1_in   <= pix(p_q + 2'd1, 2'd0, 2'd0);
            row2_in   <= pix(p_q + 2'd1, 2'd0, 2'd1);
            row3_in   <= pix(p_q + 2'd1, 2'd0, 2'd2);
          end
        end
        FIN: begin
          state_q <= IDLE;
          p_q     <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_A            = en_pipe_q;
  assign en_reg_Acc          = en_pipe_q;
  assign sel_en_demux_result = sel_q;
  assign sel_en_demux_c_reg  = sel_q;

  for (genvar k = 0; k < 9; k++) begin : g_b_out
    assign b_out[8*k +: 8] = w_q[k];
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: reset/abort, full jobs with steady and
// toggled in_valid, cycle-accurate trace from the last pixel beat to done.
module tb_systolic_array_ctrl;

  localparam int DRAIN = 4;
  localparam int PER   = 3 + DRAIN + 1;
  localparam int LAT   = 34;
  localparam logic [71:0] W_EXP = 72'h09_08_07_06_05_04_03_02_01;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [71:0] b_out;
  logic [8:0]  en_reg_B;
  logic        en_reg_A;
  logic        en_reg_Acc;
  logic [7:0]  row1_in;
  logic [7:0]  row2_in;
  logic [7:0]  row3_in;
  logic [1:0]  sel_en_demux_result;
  logic [1:0]  sel_en_demux_c_reg;
  logic        input_demux_c_reg;

  systolic_array_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .busy                (busy),
    .done                (done),
    .b_out               (b_out),
    .en_reg_B            (en_reg_B),
    .en_reg_A            (en_reg_A),
    .en_reg_Acc          (en_reg_Acc),
    .row1_in             (row1_in),
    .row2_in             (row2_in),
    .row3_in             (row3_in),
    .sel_en_demux_result (sel_en_demux_result),
    .sel_en_demux_c_reg  (sel_en_demux_c_reg),
    .input_demux_c_reg   (input_demux_c_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int done_cnt;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // FEED vectors for pixels 0..15 (X[r][c] = 4r+c): window p, column j -> rows.
  typedef struct {
    logic [1:0] p;
    logic [1:0] j;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
  } feed_vec_t;

  feed_vec_t feed_tbl [12];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] dut_vec();
    return {in_ready, busy, done, en_reg_B, en_reg_A, en_reg_Acc, input_demux_c_reg,
            sel_en_demux_result, sel_en_demux_c_reg, row1_in, row2_in, row3_in};
  endfunction

  function automatic logic [42:0] exp_vec(input logic ir, input logic bz, input logic dn,
                                          input logic [8:0] enb, input logic ena,
                                          input logic strb, input logic [1:0] sel,
                                          input logic [7:0] r1, input logic [7:0] r2,
                                          input logic [7:0] r3);
    return {ir, bz, dn, enb, ena, ena, strb, sel, sel, r1, r2, r3};
  endfunction

  // One job: 25 beats (optionally with an idle cycle after each), then the
  // cycle-by-cycle trace from PRELOAD (k=1) to FIN (k=LAT).
  task automatic run_job(input bit toggle, input bit poke_start, input int job_id);
    logic       dn;
    logic [8:0] enb;
    logic       ena;
    logic       strb;
    logic [1:0] sel;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    int         w;
    int         o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("job%0d load entry busy/in_ready", job_id), {busy, in_ready}, 2'b11);
    for (int i = 0; i < 25; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 9) ? 8'(i + 1) : 8'(i - 9);
      if (i == 8 || i == 24)
        check($sformatf("job%0d in_ready beat %0d", job_id, i), in_ready, 1'b1);
      @(negedge clk);
      if (toggle && i != 24) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        check($sformatf("job%0d in_ready gap %0d", job_id, i), in_ready, 1'b1);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int k = 1; k <= LAT; k++) begin
      dn = 1'b0; enb = '0; ena = 1'b0; strb = 1'b0; sel = '0;
      r1 = '0; r2 = '0; r3 = '0;
      if (k == 1) begin
        enb = 9'h1FF;
      end else if (k == LAT) begin
        dn = 1'b1;
      end else begin
        w   = (k - 2) / PER;
        o   = (k - 2) % PER;
        sel = 2'(w);
        if (o < 3) begin
          ena = 1'b1;
          sel = feed_tbl[w*3 + o].p;
          r1  = feed_tbl[w*3 + o].r1;
          r2  = feed_tbl[w*3 + o].r2;
          r3  = feed_tbl[w*3 + o].r3;
        end else if (o < 3 + DRAIN) begin
          ena = 1'b1;
        end else begin
          strb = 1'b1;
        end
      end
      check($sformatf("job%0d trace k=%0d", job_id, k), dut_vec(),
            exp_vec(1'b0, 1'b1, dn, enb, ena, strb, sel, r1, r2, r3));
      if (k == 1) check($sformatf("job%0d b_out preload", job_id), b_out, W_EXP);
      start = (poke_start && k == 3);
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    check($sformatf("job%0d idle after fin", job_id), dut_vec(), 43'd0);
    check($sformatf("job%0d b_out retained", job_id), b_out, W_EXP);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    feed_tbl[0]  = '{2'd0, 2'd0, 8'd0, 8'd4,  8'd8};
    feed_tbl[1]  = '{2'd0, 2'd1, 8'd1, 8'd5,  8'd9};
    feed_tbl[2]  = '{2'd0, 2'd2, 8'd2, 8'd6,  8'd10};
    feed_tbl[3]  = '{2'd1, 2'd0, 8'd1, 8'd5,  8'd9};
    feed_tbl[4]  = '{2'd1, 2'd1, 8'd2, 8'd6,  8'd10};
    feed_tbl[5]  = '{2'd1, 2'd2, 8'd3, 8'd7,  8'd11};
    feed_tbl[6]  = '{2'd2, 2'd0, 8'd4, 8'd8,  8'd12};
    feed_tbl[7]  = '{2'd2, 2'd1, 8'd5, 8'd9,  8'd13};
    feed_tbl[8]  = '{2'd2, 2'd2, 8'd6, 8'd10, 8'd14};
    feed_tbl[9]  = '{2'd3, 2'd0, 8'd5, 8'd9,  8'd13};
    feed_tbl[10] = '{2'd3, 2'd1, 8'd6, 8'd10, 8'd14};
    feed_tbl[11] = '{2'd3, 2'd2, 8'd7, 8'd11, 8'd15};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset outputs", dut_vec(), 43'd0);
    check("reset b_out", b_out, 72'd0);
    rst = 1'b0;
    @(negedge clk);

    // Job 0: aborted by reset after 9 weights and 5 pixels.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("abort mid LOAD_X busy/in_ready", {busy, in_ready}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("abort reset outputs", dut_vec(), 43'd0);
    check("abort reset b_out", b_out, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort no done", 72'(done_cnt), 72'd0);
    check("abort idle", dut_vec(), 43'd0);
    @(negedge clk);

    // Job 1: fresh full load after the abort, in_valid held high.
    run_job(1'b0, 1'b0, 1);
    check("job1 done count", 72'(done_cnt), 72'd1);

    // Job 2: in_valid toggling 1010..., start poked during FEED.
    @(negedge clk);
    run_job(1'b1, 1'b1, 2);
    repeat (4) @(negedge clk);
    #1;
    check("job2 start ignored busy", busy, 1'b0);
    check("job2 done count", 72'(done_cnt), 72'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
